// File: rtl/step_gen.sv
// step_gen: converts drive-enable / direction / period commands into
// STEP/DIR/EN signals for a stepper power stage and tracks signed position.
module step_gen #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned PULSE_W   = 8,
    parameter int unsigned DIR_SETUP = 4,
    parameter int unsigned POS_W     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    drv_en,
    input  logic                    dir,
    input  logic [WIDTH-1:0]        period,
    input  logic                    period_valid,
    output logic                    step,
    output logic                    dir_out,
    output logic                    en_out,
    output logic                    busy,
    output logic signed [POS_W-1:0] position
);

    localparam logic [WIDTH-1:0] MIN_PERIOD = WIDTH'(2 * PULSE_W);
    localparam logic [WIDTH-1:0] PULSE_LAST = WIDTH'(PULSE_W - 1);
    localparam logic [WIDTH-1:0] SETUP_LAST = WIDTH'(DIR_SETUP - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DIR_SET    = 2'd1,
        PULSE_HIGH = 2'd2,
        PULSE_LOW  = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_d;
    logic [WIDTH-1:0]        period_r;
    logic [WIDTH-1:0]        period_act;
    logic [WIDTH-1:0]        period_act_d;
    logic [WIDTH-1:0]        period_eff;
    logic [WIDTH-1:0]        cnt;
    logic [WIDTH-1:0]        cnt_d;
    logic                    step_d;
    logic                    dir_out_d;
    logic                    en_d;
    logic signed [POS_W-1:0] position_d;

    // Effective period: non-zero requests shorter than one full pulse plus
    // an equal low time are stretched so the low phase is never a runt.
    always_comb begin
        period_eff = period_r;
        if ((period_r != '0) && (period_r < MIN_PERIOD)) begin
            period_eff = MIN_PERIOD;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic; PULSE_HIGH and the low phase always run to completion
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (drv_en && (period_r != '0)) begin
                    state_d = (dir != dir_out) ? DIR_SET : PULSE_HIGH;
                end
            end
            DIR_SET: begin
                if (!drv_en) begin
                    state_d = IDLE;
                end else if (cnt == SETUP_LAST) begin
                    state_d = PULSE_HIGH;
                end
            end
            PULSE_HIGH: begin
                if (cnt == PULSE_LAST) begin
                    state_d = PULSE_LOW;
                end
            end
            PULSE_LOW: begin
                if (cnt == (period_act - WIDTH'(1))) begin
                    if (!drv_en || (period_r == '0)) begin
                        state_d = IDLE;
                    end else if (dir != dir_out) begin
                        state_d = DIR_SET;
                    end else begin
                        state_d = PULSE_HIGH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values, driven by the transition being taken
    always_comb begin
        step_d       = step;
        dir_out_d    = dir_out;
        cnt_d        = cnt;
        period_act_d = period_act;
        position_d   = position;
        en_d         = (state_d != IDLE);
        if (state_d == IDLE) begin
            step_d = 1'b0;
            cnt_d  = '0;
        end else if ((state_d == DIR_SET) && (state != DIR_SET)) begin
            dir_out_d = dir;
            cnt_d     = '0;
        end else if ((state_d == PULSE_HIGH) && (state != PULSE_HIGH)) begin
            step_d       = 1'b1;
            cnt_d        = '0;
            period_act_d = period_eff;
            position_d   = dir_out ? (position + POS_W'(1)) : (position - POS_W'(1));
        end else begin
            cnt_d = cnt + WIDTH'(1);
            if (state_d == PULSE_LOW) begin
                step_d = 1'b0;
            end
        end
    end

    // Registered outputs and step datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step       <= 1'b0;
            dir_out    <= 1'b0;
            en_out     <= 1'b0;
            cnt        <= '0;
            period_act <= '0;
            position   <= '0;
        end else begin
            step       <= step_d;
            dir_out    <= dir_out_d;
            en_out     <= en_d;
            cnt        <= cnt_d;
            period_act <= period_act_d;
            position   <= position_d;
        end
    end

    // Commanded period; a strobe mid-step only affects the next step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_r <= '0;
        end else if (period_valid) begin
            period_r <= period;
        end
    end

    assign busy = en_out;

endmodule

// File: tb/tb_step_gen.sv
// Directed bench for step_gen: default-parameter instance for timing and a
// narrow-position instance for two's-complement wrap.
module tb_step_gen;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned POS_W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b0;
    logic              drv_en = 1'b0;
    logic              dir = 1'b0;
    logic              period_valid = 1'b0;
    logic [WIDTH-1:0]  period = '0;
    logic              step, dir_out, en_out, busy;
    logic [POS_W-1:0]  position;

    logic              w_drv_en = 1'b0;
    logic              w_dir = 1'b0;
    logic              w_pv = 1'b0;
    logic [WIDTH-1:0]  w_period = '0;
    logic              w_step, w_dir_out, w_en_out, w_busy;
    logic [3:0]        w_position;

    int checks = 0;
    int passed = 0;

    step_gen #(.WIDTH(WIDTH), .PULSE_W(8), .DIR_SETUP(4), .POS_W(POS_W)) dut (
        .clk(clk), .rst(rst), .drv_en(drv_en), .dir(dir), .period(period),
        .period_valid(period_valid), .step(step), .dir_out(dir_out),
        .en_out(en_out), .busy(busy), .position(position)
    );

    step_gen #(.WIDTH(WIDTH), .PULSE_W(1), .DIR_SETUP(1), .POS_W(4)) dut_w (
        .clk(clk), .rst(rst), .drv_en(w_drv_en), .dir(w_dir), .period(w_period),
        .period_valid(w_pv), .step(w_step), .dir_out(w_dir_out),
        .en_out(w_en_out), .busy(w_busy), .position(w_position)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until the next rising edge of step (bounded by max)
    task automatic next_rise(input int max, output int n);
        n = 0;
        while (step && n < max) begin tick(); n++; end
        while (!step && n < max) begin tick(); n++; end
    endtask

    // Ticks while step stays high (bounded by max)
    task automatic high_len(input int max, output int n);
        n = 0;
        while (step && n < max) begin tick(); n++; end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (step !== 1'b0) $display("FAIL reset_step got %b exp 0", step); else passed++;
        checks++; if (en_out !== 1'b0 || busy !== 1'b0) $display("FAIL reset_en got %b/%b exp 0/0", en_out, busy); else passed++;
        checks++; if (position !== 32'h0) $display("FAIL reset_pos got %h exp 0", position); else passed++;
        checks++; if (dir_out !== 1'b0) $display("FAIL reset_dir got %b exp 0", dir_out); else passed++;
        tick(); tick();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (en_out !== 1'b0 || step !== 1'b0) $display("FAIL reset_idle en %b step %b exp 0 0", en_out, step); else passed++;
    endtask

    task automatic test_steady();
        int n;
        period = 16'd100; period_valid = 1'b1; dir = 1'b1; drv_en = 1'b1;
        tick();
        period_valid = 1'b0;
        checks++; if (en_out !== 1'b0) $display("FAIL steady_load_idle en got %b exp 0", en_out); else passed++;
        tick();
        checks++; if (dir_out !== 1'b1 || step !== 1'b0 || en_out !== 1'b1) $display("FAIL steady_dirset dir %b step %b en %b exp 1 0 1", dir_out, step, en_out); else passed++;
        next_rise(50, n);
        checks++; if (n !== 4) $display("FAIL steady_setup got %0d exp 4", n); else passed++;
        checks++; if (position !== 32'd1) $display("FAIL steady_pos1 got %0d exp 1", position); else passed++;
        high_len(50, n);
        checks++; if (n !== 8) $display("FAIL steady_high got %0d exp 8", n); else passed++;
        next_rise(300, n);
        checks++; if (n !== 92) $display("FAIL steady_low got %0d exp 92", n); else passed++;
        checks++; if (position !== 32'd2) $display("FAIL steady_pos2 got %0d exp 2", position); else passed++;
        next_rise(300, n);
        checks++; if (n !== 100) $display("FAIL steady_spacing got %0d exp 100", n); else passed++;
        checks++; if (position !== 32'd3) $display("FAIL steady_pos3 got %0d exp 3", position); else passed++;
    endtask

    task automatic test_reversal();
        int n;
        dir = 1'b0;
        high_len(50, n);
        checks++; if (n !== 8) $display("FAIL rev_high got %0d exp 8", n); else passed++;
        checks++; if (dir_out !== 1'b1) $display("FAIL rev_dir_hold got %b exp 1", dir_out); else passed++;
        next_rise(300, n);
        checks++; if (n !== 96) $display("FAIL rev_spacing got %0d exp 96", n); else passed++;
        checks++; if (dir_out !== 1'b0) $display("FAIL rev_dir got %b exp 0", dir_out); else passed++;
        checks++; if (position !== 32'd2) $display("FAIL rev_pos got %0d exp 2", position); else passed++;
    endtask

    task automatic test_period_update();
        int n, m, k;
        period = 16'd40; period_valid = 1'b1; tick(); period_valid = 1'b0;
        next_rise(300, m);
        checks++; if (m + 1 !== 100) $display("FAIL per_keep got %0d exp 100", m + 1); else passed++;
        checks++; if (position !== 32'd1) $display("FAIL per_pos5 got %0d exp 1", position); else passed++;
        next_rise(300, n);
        checks++; if (n !== 40) $display("FAIL per_40 got %0d exp 40", n); else passed++;
        period = 16'd5; period_valid = 1'b1; tick(); period_valid = 1'b0;
        next_rise(300, m);
        checks++; if (m + 1 !== 40) $display("FAIL per_keep40 got %0d exp 40", m + 1); else passed++;
        checks++; if (position !== 32'hFFFF_FFFF) $display("FAIL per_neg_wrap got %h exp ffffffff", position); else passed++;
        next_rise(300, n);
        checks++; if (n !== 16) $display("FAIL per_clamp got %0d exp 16", n); else passed++;
        checks++; if (position !== 32'hFFFF_FFFE) $display("FAIL per_pos8 got %h exp fffffffe", position); else passed++;
        period = 16'd0; period_valid = 1'b1; tick(); period_valid = 1'b0;
        high_len(50, m);
        checks++; if (m + 1 !== 8) $display("FAIL per_clamp_high got %0d exp 8", m + 1); else passed++;
        k = 0;
        while (en_out && k < 300) begin tick(); k++; end
        checks++; if (1 + m + k !== 16) $display("FAIL per_zero_stop got %0d exp 16", 1 + m + k); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL per_zero_busy got %b exp 0", busy); else passed++;
        m = 0;
        repeat (50) begin tick(); if (step) m++; end
        checks++; if (m !== 0 || position !== 32'hFFFF_FFFE) $display("FAIL per_zero_quiet steps %0d pos %h exp 0 fffffffe", m, position); else passed++;
    endtask

    task automatic test_enable_drop();
        int n, k;
        period = 16'd100; period_valid = 1'b1; tick(); period_valid = 1'b0;
        tick();
        checks++; if (step !== 1'b1 || en_out !== 1'b1) $display("FAIL en_latency step %b en %b exp 1 1", step, en_out); else passed++;
        checks++; if (position !== 32'hFFFF_FFFD) $display("FAIL en_pos got %h exp fffffffd", position); else passed++;
        tick();
        drv_en = 1'b0;
        high_len(50, n);
        checks++; if (n + 1 !== 8) $display("FAIL en_high got %0d exp 8", n + 1); else passed++;
        k = 0;
        while (en_out && k < 300) begin tick(); k++; end
        checks++; if (k !== 92) $display("FAIL en_low got %0d exp 92", k); else passed++;
        n = 0;
        repeat (150) begin tick(); if (step || en_out) n++; end
        checks++; if (n !== 0 || position !== 32'hFFFF_FFFD) $display("FAIL en_quiet active %0d pos %h exp 0 fffffffd", n, position); else passed++;
    endtask

    task automatic test_dirset_abort();
        int n;
        dir = 1'b1; drv_en = 1'b1;
        tick();
        checks++; if (dir_out !== 1'b1 || en_out !== 1'b1) $display("FAIL abort_enter dir %b en %b exp 1 1", dir_out, en_out); else passed++;
        drv_en = 1'b0;
        tick();
        checks++; if (en_out !== 1'b0) $display("FAIL abort_idle en got %b exp 0", en_out); else passed++;
        n = 0;
        repeat (10) begin tick(); if (step) n++; end
        checks++; if (n !== 0 || position !== 32'hFFFF_FFFD) $display("FAIL abort_nostep steps %0d pos %h exp 0 fffffffd", n, position); else passed++;
    endtask

    task automatic test_reset_mid_pulse();
        drv_en = 1'b1;
        tick();
        checks++; if (step !== 1'b1 || position !== 32'hFFFF_FFFE) $display("FAIL rstmid_start step %b pos %h exp 1 fffffffe", step, position); else passed++;
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++; if (step !== 1'b0 || en_out !== 1'b0 || busy !== 1'b0) $display("FAIL rstmid_async step %b en %b busy %b exp 0 0 0", step, en_out, busy); else passed++;
        checks++; if (position !== 32'h0 || dir_out !== 1'b0) $display("FAIL rstmid_pos pos %h dir %b exp 0 0", position, dir_out); else passed++;
        tick();
        rst = 1'b1;
        repeat (5) tick();
        checks++; if (en_out !== 1'b0 || step !== 1'b0) $display("FAIL rstmid_period_cleared en %b step %b exp 0 0", en_out, step); else passed++;
        drv_en = 1'b0;
    endtask

    task automatic test_wrap();
        int   rises, t, t7, t8;
        logic prev;
        logic [3:0] p7, p8;
        rises = 0; t = 0; t7 = 0; t8 = 0; p7 = '0; p8 = '0; prev = 1'b0;
        w_period = 16'd2; w_pv = 1'b1; w_dir = 1'b1;
        tick();
        w_pv = 1'b0; w_drv_en = 1'b1;
        while (rises < 8 && t < 200) begin
            tick(); t++;
            if (w_step && !prev) begin
                rises++;
                if (rises == 7) begin p7 = w_position; t7 = t; end
                if (rises == 8) begin p8 = w_position; t8 = t; end
            end
            prev = w_step;
        end
        w_drv_en = 1'b0;
        checks++; if (rises !== 8) $display("FAIL wrap_rises got %0d exp 8", rises); else passed++;
        checks++; if (p7 !== 4'h7) $display("FAIL wrap_max got %h exp 7", p7); else passed++;
        checks++; if (p8 !== 4'h8) $display("FAIL wrap_min got %h exp 8", p8); else passed++;
        checks++; if (t8 - t7 !== 2) $display("FAIL wrap_spacing got %0d exp 2", t8 - t7); else passed++;
    endtask

    initial begin
        test_reset();
        test_steady();
        test_reversal();
        test_period_update();
        test_enable_drop();
        test_dirset_abort();
        test_reset_mid_pulse();
        test_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
